// File: rtl/mmu_xlate_ctrl.sv
// MIPS-style translation controller: one request in flight, TLB sampled after TLB_WAIT LOOKUP cycles, Mem_Valid held until Mem_Ready.
// Define MMU_KSEG_BYPASS_EN to let kernel kseg0/kseg1 accesses skip the TLB (PA = VA & 0x1FFF_FFFF).
module mmu_xlate_ctrl #(
  parameter int PABITS   = 32,
  parameter int TLB_WAIT = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [31:0]       Req_VAddr,
  input  logic              Req_Write,
  input  logic [7:0]        Cur_ASID,
  input  logic              Kernel_Mode,
  input  logic              CP0_Update,
  output logic [19:0]       TLB_VPN,
  output logic [7:0]        TLB_ASID,
  output logic              TLB_RW_En,
  input  logic              TLB_Match,
  input  logic              TLB_Valid,
  input  logic              TLB_Modified,
  input  logic [19:0]       TLB_PFN,
  output logic              Mem_Valid,
  input  logic              Mem_Ready,
  output logic [PABITS-1:0] Mem_PAddr,
  output logic              Mem_Write,
  output logic              Exc_Valid,
  output logic [4:0]        Exc_Code,
  output logic              Exc_Refill,
  output logic [31:0]       Exc_BadVAddr
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE, FAULT} state_t;

  localparam logic [1:0] WAIT_M1 = 2'(TLB_WAIT - 1);
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [31:0]       va_q;
  logic              write_q;
  logic [7:0]        asid_q;
  logic [PABITS-1:0] paddr_q;
  logic [4:0]        code_q;
  logic              refill_q;
  logic [31:0]       badva_q;

  logic              accept;
  logic              pa_ld;
  logic [31:0]       pa32;
  logic [PABITS-1:0] pa_fit;
  logic              exc_ld;
  logic [4:0]        code_nxt;
  logic              refill_nxt;
  logic [31:0]       badva_nxt;
  logic              addr_err;
  logic              bypass;

  assign addr_err = !Kernel_Mode && Req_VAddr[31];
`ifdef MMU_KSEG_BYPASS_EN
  assign bypass = Kernel_Mode && (Req_VAddr[31:30] == 2'b10);
`else
  assign bypass = 1'b0;
`endif

  // {PFN,offset} is a 32-bit quantity; fit it to the physical bus width.
  generate
    if (PABITS <= 32) begin : g_trunc
      assign pa_fit = pa32[PABITS-1:0];
    end else begin : g_ext
      assign pa_fit = {{(PABITS-32){1'b0}}, pa32};
    end
  endgenerate

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    pa_ld      = 1'b0;
    pa32       = '0;
    exc_ld     = 1'b0;
    code_nxt   = '0;
    refill_nxt = 1'b0;
    badva_nxt  = va_q;
    case (state)
      IDLE: begin
        if (Req_Valid) begin
          accept = 1'b1;
          if (addr_err) begin
            state_nxt = FAULT;
            exc_ld    = 1'b1;
            code_nxt  = Req_Write ? EXC_ADES : EXC_ADEL;
            badva_nxt = Req_VAddr;
          end else if (bypass) begin
            state_nxt = ISSUE;
            pa_ld     = 1'b1;
            pa32      = Req_VAddr & 32'h1FFF_FFFF;
          end else begin
            state_nxt = LOOKUP;
            cnt_nxt   = WAIT_M1;
          end
        end
      end
      LOOKUP: begin
        // A TLB write restarts the wait so a half-written entry is never sampled.
        if (CP0_Update) begin
          cnt_nxt = WAIT_M1;
        end else if (cnt != 2'd0) begin
          cnt_nxt = cnt - 2'd1;
        end else if (TLB_Match) begin
          state_nxt = ISSUE;
          pa_ld     = 1'b1;
          pa32      = {TLB_PFN, va_q[11:0]};
        end else begin
          state_nxt = FAULT;
          exc_ld    = 1'b1;
          if (TLB_Modified) begin
            code_nxt = EXC_MOD;
          end else begin
            code_nxt   = write_q ? EXC_TLBS : EXC_TLBL;
            refill_nxt = TLB_Valid;
          end
        end
      end
      ISSUE: begin
        if (Mem_Ready) state_nxt = IDLE;
      end
      FAULT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      va_q     <= '0;
      write_q  <= 1'b0;
      asid_q   <= '0;
      paddr_q  <= '0;
      code_q   <= '0;
      refill_q <= 1'b0;
      badva_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        va_q    <= Req_VAddr;
        write_q <= Req_Write;
        asid_q  <= Cur_ASID;
      end
      if (pa_ld) paddr_q <= pa_fit;
      if (exc_ld) begin
        code_q   <= code_nxt;
        refill_q <= refill_nxt;
        badva_q  <= badva_nxt;
      end
    end
  end

  assign Req_Ready    = (state == IDLE);
  assign Mem_Valid    = (state == ISSUE);
  assign Exc_Valid    = (state == FAULT);
  assign TLB_VPN      = va_q[31:12];
  assign TLB_ASID     = asid_q;
  assign TLB_RW_En    = !write_q;
  assign Mem_PAddr    = paddr_q;
  assign Mem_Write    = write_q;
  assign Exc_Code     = code_q;
  assign Exc_Refill   = refill_q;
  assign Exc_BadVAddr = badva_q;

endmodule

// File: tb/tb_mmu_xlate_ctrl.sv
// Randomized bench for mmu_xlate_ctrl against a request-level model and an emulated single-entry TLB.
module tb_mmu_xlate_ctrl;
  localparam int TW = 2;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [31:0] Req_VAddr;
  logic        Req_Write;
  logic [7:0]  Cur_ASID;
  logic        Kernel_Mode;
  logic        CP0_Update;
  logic [19:0] TLB_VPN;
  logic [7:0]  TLB_ASID;
  logic        TLB_RW_En;
  logic        TLB_Match;
  logic        TLB_Valid;
  logic        TLB_Modified;
  logic [19:0] TLB_PFN;
  logic        Mem_Valid;
  logic        Mem_Ready;
  logic [31:0] Mem_PAddr;
  logic        Mem_Write;
  logic        Exc_Valid;
  logic [4:0]  Exc_Code;
  logic        Exc_Refill;
  logic [31:0] Exc_BadVAddr;

  // Emulated TLB entry
  logic [19:0] e_vpn;
  logic [7:0]  e_asid;
  logic        e_v;
  logic        e_d;
  logic [19:0] e_pfn;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign TLB_Match    = (TLB_VPN == e_vpn) && (TLB_ASID == e_asid) && e_v && (TLB_RW_En || e_d);
  assign TLB_Valid    = e_v;
  assign TLB_Modified = (TLB_VPN == e_vpn) && (TLB_ASID == e_asid) && e_v && !TLB_RW_En && !e_d;
  assign TLB_PFN      = e_pfn;

  mmu_xlate_ctrl #(.PABITS(32), .TLB_WAIT(TW)) dut (
    .clk(clk), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_VAddr(Req_VAddr), .Req_Write(Req_Write),
    .Cur_ASID(Cur_ASID), .Kernel_Mode(Kernel_Mode), .CP0_Update(CP0_Update),
    .TLB_VPN(TLB_VPN), .TLB_ASID(TLB_ASID), .TLB_RW_En(TLB_RW_En),
    .TLB_Match(TLB_Match), .TLB_Valid(TLB_Valid), .TLB_Modified(TLB_Modified), .TLB_PFN(TLB_PFN),
    .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready), .Mem_PAddr(Mem_PAddr), .Mem_Write(Mem_Write),
    .Exc_Valid(Exc_Valid), .Exc_Code(Exc_Code), .Exc_Refill(Exc_Refill), .Exc_BadVAddr(Exc_BadVAddr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, {Req_Ready, Mem_Valid, Exc_Valid, Exc_Refill, TLB_RW_En, Mem_Write}, 6'b100010);
    chk({tag, "_code"}, Exc_Code, 5'd0);
    chk({tag, "_paddr"}, Mem_PAddr, 32'd0);
    chk({tag, "_badva"}, Exc_BadVAddr, 32'd0);
    chk({tag, "_tlbreq"}, {TLB_VPN, TLB_ASID}, 28'd0);
  endtask

  task automatic set_entry(input logic [19:0] vpn, input logic [7:0] asid, input logic v,
                           input logic d, input logic [19:0] pfn);
    e_vpn = vpn; e_asid = asid; e_v = v; e_d = d; e_pfn = pfn;
  endtask

  // Random entry biased towards the page/ASID of the current request.
  task automatic rand_entry(input logic [31:0] va, input logic [7:0] asid);
    e_vpn  = ($urandom_range(0, 3) != 0) ? va[31:12] : 20'($urandom);
    e_asid = ($urandom_range(0, 3) != 0) ? asid : 8'($urandom);
    e_v    = ($urandom_range(0, 3) != 0);
    e_d    = ($urandom_range(0, 1) != 0);
    e_pfn  = 20'($urandom);
  endtask

  task automatic do_req(input logic [31:0] va, input logic wr, input logic km,
                        input logic [7:0] asid, input bit allow_cp0, input int rdy_hold);
    bit          exp_exc;
    bit          byp;
    bit          cp;
    int          streak;
    int          n;
    logic [4:0]  code;
    logic        refill;
    logic [31:0] pa;
    bit          hit;
    exp_exc = 1'b0; code = '0; refill = 1'b0; pa = '0; byp = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", Req_Ready, 1'b1);
    Req_Valid = 1'b1; Req_VAddr = va; Req_Write = wr; Cur_ASID = asid; Kernel_Mode = km;
    @(negedge clk);
    Req_Valid = 1'b0; Req_VAddr = $urandom; Req_Write = $urandom_range(0, 1);
    Cur_ASID = 8'($urandom); Kernel_Mode = $urandom_range(0, 1);
`ifdef MMU_KSEG_BYPASS_EN
    byp = km && (va[31:30] == 2'b10);
`endif
    if (!km && va[31]) begin
      exp_exc = 1'b1;
      code    = wr ? 5'd5 : 5'd4;
    end else if (byp) begin
      pa = va & 32'h1FFF_FFFF;
    end else begin
      // Sample happens once the last TW lookup cycles saw no TLB write.
      streak = 0;
      n = 0;
      while (1) begin
        chk("lookup_state", {Mem_Valid, Exc_Valid, Req_Ready}, 3'b000);
        chk("lookup_tlbreq", {TLB_RW_En, TLB_ASID, TLB_VPN}, {!wr, asid, va[31:12]});
        cp = allow_cp0 && (n < 12) && ($urandom_range(0, 3) == 0);
        CP0_Update = cp;
        if (cp && ($urandom_range(0, 1) != 0)) rand_entry(va, asid);
        streak = cp ? 0 : streak + 1;
        if (streak >= TW) break;
        @(negedge clk);
        n++;
      end
      hit = (e_vpn == va[31:12]) && (e_asid == asid) && e_v;
      if (hit && !(wr && !e_d)) begin
        pa = {e_pfn, va[11:0]};
      end else begin
        exp_exc = 1'b1;
        if (hit) code = 5'd1;
        else begin
          code   = wr ? 5'd3 : 5'd2;
          refill = e_v;
        end
      end
      @(negedge clk);
      CP0_Update = 1'b0;
    end
    if (exp_exc) begin
      chk("exc_pulse", {Exc_Valid, Mem_Valid, Req_Ready}, 3'b100);
      chk("exc_code", Exc_Code, code);
      chk("exc_refill", Exc_Refill, refill);
      chk("exc_badva", Exc_BadVAddr, va);
      @(negedge clk);
      chk("exc_end", {Exc_Valid, Mem_Valid, Req_Ready}, 3'b001);
      chk("exc_hold", {Exc_Code, Exc_Refill, Exc_BadVAddr}, {code, refill, va});
    end else begin
      for (int i = 0; i < rdy_hold; i++) begin
        chk("mem_wait", {Mem_Valid, Exc_Valid, Req_Ready}, 3'b100);
        chk("mem_wait_pa", {Mem_Write, Mem_PAddr}, {wr, pa});
        Mem_Ready = 1'b0;
        @(negedge clk);
      end
      chk("mem_issue", {Mem_Valid, Exc_Valid, Req_Ready}, 3'b100);
      chk("mem_pa", {Mem_Write, Mem_PAddr}, {wr, pa});
      Mem_Ready = 1'b1;
      @(negedge clk);
      Mem_Ready = 1'b0;
      chk("mem_done", {Mem_Valid, Req_Ready}, 2'b01);
    end
  endtask

  initial begin
    logic [31:0] va;
    logic        wr;
    logic        km;
    logic [7:0]  asid;
    Reset = 1'b0; Req_Valid = 1'b0; Req_VAddr = '0; Req_Write = 1'b0; Cur_ASID = '0;
    Kernel_Mode = 1'b0; CP0_Update = 1'b0; Mem_Ready = 1'b0;
    set_entry(20'h00400, 8'd5, 1'b1, 1'b1, 20'h12345);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    Reset = 1'b1;

    // Directed scenarios
    do_req(32'h0040_0ABC, 1'b0, 1'b0, 8'd5, 1'b0, 0);
    set_entry(20'h00400, 8'd5, 1'b1, 1'b0, 20'h12345);
    do_req(32'h0040_0ABC, 1'b1, 1'b0, 8'd5, 1'b0, 0);
    set_entry(20'h00400, 8'd5, 1'b1, 1'b1, 20'h12345);
    do_req(32'h7FFF_0000, 1'b0, 1'b0, 8'd5, 1'b0, 0);
    set_entry(20'h00400, 8'd5, 1'b0, 1'b1, 20'h12345);
    do_req(32'h7FFF_0000, 1'b0, 1'b0, 8'd5, 1'b0, 0);
    do_req(32'h8000_1000, 1'b1, 1'b0, 8'd5, 1'b0, 0);
    set_entry(20'hA0001, 8'd5, 1'b1, 1'b1, 20'h00777);
    do_req(32'hA000_1000, 1'b0, 1'b1, 8'd5, 1'b0, 0);
    set_entry(20'h00400, 8'd5, 1'b1, 1'b1, 20'h12345);
    do_req(32'h0040_0ABC, 1'b1, 1'b0, 8'd5, 1'b0, 5);

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0: va = {1'b0, 31'($urandom)};
        1: va = {3'b100, 29'($urandom)};
        2: va = {3'b101, 29'($urandom)};
        default: va = {2'b11, 30'($urandom)};
      endcase
      wr   = $urandom_range(0, 1);
      km   = $urandom_range(0, 1);
      asid = 8'($urandom_range(0, 3));
      rand_entry(va, asid);
      do_req(va, wr, km, asid, 1'b1, $urandom_range(0, 3));
    end

    // Reset while a request waits in ISSUE
    set_entry(20'h00400, 8'd5, 1'b1, 1'b1, 20'h12345);
    @(negedge clk);
    Req_Valid = 1'b1; Req_VAddr = 32'h0040_0123; Req_Write = 1'b1; Cur_ASID = 8'd5; Kernel_Mode = 1'b0;
    @(negedge clk);
    Req_Valid = 1'b0;
    Mem_Ready = 1'b0;
    repeat (TW) @(negedge clk);
    chk("pre_reset_issue", {Mem_Valid, Mem_PAddr}, {1'b1, 32'h1234_5123});
    Reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset_mid_issue");
    Reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {Req_Ready, Mem_Valid}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
